// File: rtl/qduc_pkg.sv
// qduc_pkg: constants, FSM states and the I/Q pair type shared by the TX FIFO and the upconverter.
package qduc_pkg;

    localparam int ISZ       = 16;
    localparam int RATE_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic signed [ISZ-1:0] i;
        logic signed [ISZ-1:0] q;
    } iq_t;

endpackage

// File: rtl/qduc_tx_fifo_if.sv
// qduc_tx_fifo_if: producer-to-FIFO valid/ready handshake carrying one signed I/Q pair.
//   s_valid  producer has a pair on s_i/s_q
//   s_ready  FIFO can accept; a push happens when s_valid && s_ready
//   s_i/s_q  signed ISZ-bit pair
//   master = producer side, slave = FIFO side
interface qduc_tx_fifo_if;
    import qduc_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic signed [ISZ-1:0] s_i;
    logic signed [ISZ-1:0] s_q;

    modport master (output s_valid, s_i, s_q, input s_ready);
    modport slave  (input s_valid, s_i, s_q, output s_ready);

endinterface

// File: rtl/qduc_tx_fifo_mem.sv
// qduc_tx_fifo_mem: 2^AW x DW simple dual-port RAM, one write port and one registered read port.
//   clk    clock
//   we     write enable, stores wdata at waddr
//   re     read enable, rdata takes ram[raddr] at the edge and holds otherwise
module qduc_tx_fifo_mem #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] ram [2**AW];

    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
        if (re) rdata <= ram[raddr];
    end

endmodule

// File: rtl/qduc_tx_fifo.sv
// qduc_tx_fifo: TX sample FIFO that feeds one held I/Q pair per interpolation period to the CIC.
//   clk           sample clock shared with the upconverter
//   reset         synchronous, active-high
//   enable        run request; low flushes the FIFO and returns to IDLE
//   up            producer handshake (qduc_tx_fifo_if.slave)
//   out_i/out_q   held signed sample, updated mid-period
//   out_stb       one-cycle pulse when the divider is all ones
//   level         FIFO occupancy 0..2^DEPTH_LOG2
//   underrun      sticky underrun flag, underrun_clr clears it (a new underrun wins)
//   underrun_cnt  saturating underrun event counter, present only with
//                 QDUC_TX_FIFO_UNDERRUN_CNT_EN defined
module qduc_tx_fifo
    import qduc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int PREFILL    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    qduc_tx_fifo_if.slave         up,
    output logic signed [ISZ-1:0] out_i,
    output logic signed [ISZ-1:0] out_q,
    output logic                  out_stb,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    input  logic                  underrun_clr
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    localparam logic [DEPTH_LOG2:0]  FULL    = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]  PRE_LVL = (DEPTH_LOG2+1)'(PREFILL);
    localparam logic [RATE_LOG2-1:0] UPD     = RATE_LOG2'(2**(RATE_LOG2-1)-1);

    state_t                state, state_n;
    logic [RATE_LOG2-1:0]  div;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  push, pop, upd, ev, out_vld;
    iq_t                   rd_data;

    // Updating half a period before the strobe keeps data stable around it.
    assign upd        = div == UPD;
    assign out_stb    = div == '1;
    assign up.s_ready = level != FULL && enable && !reset;
    assign push       = up.s_valid && up.s_ready;
    // The RAM read register holds the last popped pair; out_vld masks it to 0
    // after reset, flush or underrun without touching the RAM.
    assign out_i      = out_vld ? rd_data.i : '0;
    assign out_q      = out_vld ? rd_data.q : '0;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        ev      = 1'b0;
        if (!enable) state_n = ST_IDLE;
        else begin
            case (state)
                ST_IDLE:    state_n = ST_PREFILL;
                ST_PREFILL: if (upd && level >= PRE_LVL) begin
                    state_n = ST_RUN;
                    pop     = 1'b1;
                end
                ST_RUN:     if (upd) begin
                    pop     = level != '0;
                    ev      = level == '0;
                    state_n = level == '0 ? ST_PREFILL : ST_RUN;
                end
                default:    state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            div      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_vld  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            div      <= div + RATE_LOG2'(1);
            underrun <= ev || (underrun && !underrun_clr);
            if (!enable) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                out_vld <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr + DEPTH_LOG2'(push);
                rd_ptr  <= rd_ptr + DEPTH_LOG2'(pop);
                level   <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
                out_vld <= pop || (out_vld && !ev);
            end
        end
    end

`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) underrun_cnt <= '0;
        else if (ev) underrun_cnt <= underrun_clr ? 16'd1 : underrun_cnt + 16'(underrun_cnt != 16'hFFFF);
        else if (underrun_clr) underrun_cnt <= '0;
    end
`endif

    // A pop never reads the slot being written: pop needs level > 0 and push needs level < depth.
    qduc_tx_fifo_mem #(
        .AW (DEPTH_LOG2),
        .DW (2*ISZ)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({up.s_i, up.s_q}),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_qduc_tx_fifo.sv
// tb_qduc_tx_fifo: randomized scoreboard bench for qduc_tx_fifo against a queue-based reference model.
module tb_qduc_tx_fifo;
    import qduc_pkg::*;

    typedef struct {
        logic signed [ISZ-1:0] i;
        logic signed [ISZ-1:0] q;
        logic                  ur;
        int                    lvl;
        int                    cnt;
    } rec_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic                  underrun_clr = 1'b0;
    logic signed [ISZ-1:0] out_i, out_q;
    logic                  out_stb;
    logic [6:0]            level;
    logic                  underrun;
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
    logic [15:0]           underrun_cnt;
`endif

    qduc_tx_fifo_if up ();

    qduc_tx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .up           (up),
        .out_i        (out_i),
        .out_q        (out_q),
        .out_stb      (out_stb),
        .level        (level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of pairs plus the state rules, advanced once per clock.
    iq_t  m_q[$];
    rec_t exp_q[$];
    int   m_div = 0;
    int   m_st = 0;
    int   m_cnt = 0;
    logic m_ur = 1'b0;
    logic signed [ISZ-1:0] m_oi = '0, m_oq = '0;
    bit   m_push, m_ev;
    iq_t  m_pair;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_div = 0;
            m_q.delete();
            m_st = 0;
            m_oi = '0;
            m_oq = '0;
            m_ur = 1'b0;
            m_cnt = 0;
        end else begin
            m_push = up.s_valid && enable && m_q.size() < 64;
            m_ev = 1'b0;
            if (!enable) begin
                m_q.delete();
                m_oi = '0;
                m_oq = '0;
                m_st = 0;
            end else begin
                if (m_st == 0) m_st = 1;
                else if (m_div == 127 && (m_st == 2 || m_q.size() >= 32)) begin
                    if (m_q.size() > 0) begin
                        m_pair = m_q.pop_front();
                        m_oi = m_pair.i;
                        m_oq = m_pair.q;
                        m_st = 2;
                    end else begin
                        m_oi = '0;
                        m_oq = '0;
                        m_ev = 1'b1;
                        m_st = 1;
                    end
                end
                if (m_push) m_q.push_back('{up.s_i, up.s_q});
            end
            if (m_ev) begin
                m_ur = 1'b1;
                m_cnt = underrun_clr ? 1 : (m_cnt < 65535 ? m_cnt + 1 : m_cnt);
            end else if (underrun_clr) begin
                m_ur = 1'b0;
                m_cnt = 0;
            end
            m_div = (m_div + 1) % 256;
            if (m_div == 255) exp_q.push_back('{m_oi, m_oq, m_ur, m_q.size(), m_cnt});
        end
    end

    // Monitor: every strobe must match the next expected record.
    rec_t mon_e;
    initial forever begin
        @(negedge clk);
        if (out_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL stb_unexpected: strobe with no expected record");
            end else begin
                mon_e = exp_q.pop_front();
                chk("stb_out_i", out_i, mon_e.i);
                chk("stb_out_q", out_q, mon_e.q);
                chk("stb_underrun", underrun, mon_e.ur);
                chk("stb_level", level, mon_e.lvl);
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
                chk("stb_cnt", underrun_cnt, mon_e.cnt);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input iq_t p);
        up.s_valid = 1'b1;
        up.s_i = p.i;
        up.s_q = p.q;
        tick();
        up.s_valid = 1'b0;
    endtask

    task automatic wait_div(input int d);
        for (int n = 0; n < 300 && m_div != d; n++) tick();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        up.s_valid = 1'b0;
        up.s_i = '0;
        up.s_q = '0;
        repeat (3) tick();
        chk("rst_out_i", out_i, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", up.s_ready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_stb", out_stb, 0);
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
        chk("rst_cnt", underrun_cnt, 0);
`endif
        reset = 1'b0;
        tick();
        chk("idle_ready", up.s_ready, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("en_ready", up.s_ready, 1);
        for (int n = 0; n < 32; n++) push1('{ISZ'(n), ISZ'(-n)});
        chk("prefill_level", level, 32);
        wait_div(127);
        chk("pre_upd_out_i", out_i, 0);
        chk("pre_upd_level", level, 32);
        tick();
        chk("first_out_i", out_i, 0);
        chk("first_out_q", out_q, 0);
        chk("first_level", level, 31);
        repeat (256) tick();
        chk("second_out_i", out_i, 1);
        chk("second_out_q", out_q, -1);
        // Steady state: one random push per period, anywhere after the update point.
        for (int p = 0; p < 8; p++) begin
            wait_div($urandom_range(130, 250));
            push1('{ISZ'($urandom), ISZ'($urandom)});
        end
        // Drain; pulse underrun_clr at every update so it coincides with the underrun event.
        for (int k = 0; k < 45 && !m_ur; k++) begin
            wait_div(127);
            underrun_clr = 1'b1;
            tick();
            underrun_clr = 1'b0;
        end
        chk("ur_set_wins", underrun, 1);
        chk("ur_out_i", out_i, 0);
        chk("ur_out_q", out_q, 0);
        chk("ur_level", level, 0);
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
        chk("ur_cnt", underrun_cnt, 1);
`endif
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("ur_cleared", underrun, 0);
`ifdef QDUC_TX_FIFO_UNDERRUN_CNT_EN
        chk("cnt_cleared", underrun_cnt, 0);
`endif
        wait_div(130);
        for (int n = 0; n < 64; n++) push1('{ISZ'($urandom), ISZ'($urandom)});
        chk("full_level", level, 64);
        chk("full_ready", up.s_ready, 0);
        push1('{ISZ'(16'h7FFF), ISZ'(16'h8000)});
        chk("full_no_push", level, 64);
        for (int k = 0; k < 20000 && m_q.size() != 20; k++) tick();
        wait_div(200);
        chk("pre_flush_level", level, 20);
        enable = 1'b0;
        tick();
        chk("flush_level", level, 0);
        chk("flush_out_i", out_i, 0);
        chk("flush_out_q", out_q, 0);
        chk("flush_ready", up.s_ready, 0);
        tick();
        enable = 1'b1;
        for (int c = 0; c < 12 * 256; c++) begin
            up.s_valid = $urandom_range(0, 99) == 0;
            up.s_i = ISZ'($urandom);
            up.s_q = ISZ'($urandom);
            tick();
        end
        up.s_valid = 1'b0;
        repeat (40) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_out_i", out_i, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_stb", out_stb, 0);
        chk("mid_rst_ready", up.s_ready, 0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
